// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply,
// restoring divide, single-cycle MTHI/MTLO, abort via flush.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_start_ok;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_upper;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_last;

    assign w_start_ok = start & ~flush & (r_state == S_IDLE);
    assign w_a_neg    = ~op[0] & a[WIDTH-1];
    assign w_b_neg    = ~op[0] & b[WIDTH-1];
    assign w_abs_a    = w_a_neg ? neg_w(a) : a;
    assign w_abs_b    = w_b_neg ? neg_w(b) : b;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush aborts any non-idle state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok && (op[2] == 1'b0)) begin
                    w_next = op[1] ? S_DIV : S_MUL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_FIX;
                end else begin
                    w_next = r_state;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One iteration step: acc = {upper, lower}; mul shifts right, div shifts left
    always_comb begin
        w_mul_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
        if (r_is_div) begin
            if (w_div_trial[WIDTH] == 1'b0) begin
                w_acc_nxt = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = {w_mul_upper, r_acc[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the magnitude results
    always_comb begin
        w_prod = r_neg_res ? neg_2w(r_acc) : r_acc;
        w_quo  = r_neg_res ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
        w_rem  = r_neg_rem ? neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    end

    // Datapath, HI/LO and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_a       <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                r_acc     <= op[1] ? {{WIDTH{1'b0}}, w_abs_a}
                                                   : {{WIDTH{1'b0}}, w_abs_b};
                                r_opnd    <= op[1] ? w_abs_b : w_abs_a;
                                r_cnt     <= '0;
                                r_is_div  <= op[1];
                                r_neg_res <= w_a_neg ^ w_b_neg;
                                r_neg_rem <= w_a_neg;
                                r_a       <= a;
                                r_b_zero  <= (b == '0);
                            end
                            3'b100:  r_hi <= a;
                            3'b101:  r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (!flush) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (!r_is_div) begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end else if (r_b_zero) begin
                            r_hi  <= r_a;
                            r_lo  <= '1;
                            r_dbz <= 1'b1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32 main instance, WIDTH=8 side instance).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'b000;
    logic [7:0]  a8 = 8'h0;
    logic [7:0]  b8 = 8'h0;
    logic        flush8 = 1'b0;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int tests = 0;
    int fails = 0;
    int lat, bcnt, ndone;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div op, scramble operands after capture, wait (bounded) for done
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int l, output int bc);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 3'b110;
        l = 0; bc = 0;
        while (done !== 1'b1 && l < 100) begin
            if (busy === 1'b1) bc++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);
        check("rst_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
        @(negedge clk); reset = 1'b0;

        // WIDTH=8 MULTU FF*FF
        @(negedge clk);
        start8 = 1'b1; op8 = 3'b001; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0; lat = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_latency", 64'(lat), 64'd9);
        check("w8_prod", {48'h0, hi8, lo8}, 64'h0000_0000_0000_FE01);

        // MULT -3 * 5
        run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, lat, bcnt);
        check("mult_latency", 64'(lat), 64'd33);
        check("mult_busy_cycles", 64'(bcnt), 64'd33);
        check("mult_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        check("mult_busy_at_done", {63'h0, busy}, 64'h0);
        check("mult_dbz", {63'h0, div_by_zero}, 64'h0);
        @(posedge clk); #1;
        check("done_one_cycle", {63'h0, done}, 64'h0);

        // MULTU max * max, then MTLO
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("multu_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo_hilo", {hi, lo}, 64'hFFFF_FFFE_1234_5678);
        check("mtlo_flags", {62'h0, busy, done}, 64'h0);

        // Signed divides
        run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, lat, bcnt);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        check("div_ovf_dbz", {63'h0, div_by_zero}, 64'h0);

        // DIVU by zero
        run_op(3'b011, 32'h0000_0007, 32'h0000_0000, lat, bcnt);
        check("dbz_latency", 64'(lat), 64'd33);
        check("dbz_result", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        check("dbz_flags", {62'h0, done, div_by_zero}, 64'h3);
        @(posedge clk); #1;
        check("dbz_clears", {63'h0, div_by_zero}, 64'h0);

        // MTHI
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'hAAAA_5555;
        @(posedge clk); #1;
        start = 1'b0;
        check("mthi_hilo", {hi, lo}, 64'hAAAA_5555_FFFF_FFFF);

        // Flush of an in-flight MULT at cycle 10
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'h2; b = 32'h3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {63'h0, busy}, 64'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("flush_no_done", 64'(ndone), 64'd0);
        check("flush_hilo", {hi, lo}, 64'hAAAA_5555_FFFF_FFFF);

        // start held high during busy is ignored; operands captured at start
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        op = 3'b000; a = 32'd1; b = 32'd1;
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
            if (i == 9) start = 1'b0;
        end
        check("held_start_one_done", 64'(ndone), 64'd1);
        check("held_start_result", {hi, lo}, 64'h0000_0000_0000_002A);

        // flush with start in IDLE: no MTHI write
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_idle_mthi", {hi, lo}, 64'h0000_0000_0000_002A);

        // Reserved op
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = 32'h1111_1111; b = 32'h2222_2222;
        @(posedge clk); #1;
        start = 1'b0;
        check("reserved_busy", {63'h0, busy}, 64'h0);
        @(posedge clk); #1;
        check("reserved_state", {62'h0, busy, done}, 64'h0);
        check("reserved_hilo", {hi, lo}, 64'h0000_0000_0000_002A);

        // Asynchronous reset mid-DIV
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("div_started_busy", {63'h0, busy}, 64'h1);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_hilo", {hi, lo}, 64'h0);
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        @(negedge clk); reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("async_rst_no_done", 64'(ndone), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
